// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: opcode constants, fetch-state type
// and the instruction-length helper used by both fetch and decode.
package cpu8_pkg;

  localparam logic [3:0] OPC_LOAD  = 4'h9;
  localparam logic [3:0] OPC_STORE = 4'hD;
  localparam logic [7:0] OPC_HLT   = 8'hFF;

  typedef enum logic [1:0] {
    S_OP,
    S_IMM,
    S_VALID,
    S_HALT
  } fetch_state_e;

  // LOAD and STORE carry an operand byte; every other opcode is 1 byte long.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return (opcode[7:4] == OPC_LOAD) || (opcode[7:4] == OPC_STORE);
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage of the 8-bit CPU.
// Owns the PC, drives the combinational instruction-memory address, assembles
// 1- and 2-byte instructions and hands them to decode over valid/ready.
// Stops after delivering HLT until redirected by pc_load or reset.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem_addr        memory read address (= PC)
//   imem_data        memory read data, combinational from imem_addr
//   pc_load          redirect request, priority over every state
//   pc_load_addr     redirect target
//   instr_valid      instruction presented to decode
//   instr_ready      decode accepts
//   instr_opcode     first instruction byte
//   instr_operand    second byte, 8'h00 for 1-byte instructions
//   instr_two_byte   operand field is meaningful
//   instr_pc         address of the opcode byte
//   halted           HLT delivered, fetch stopped
//   instr_count      (IFETCH_PERF_CTR_EN only) count of accepted transfers
//
// Build option: define IFETCH_PERF_CTR_EN to add the transfer counter.
module instruction_fetch
  import cpu8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_data,
  input  logic        pc_load,
  input  logic [7:0]  pc_load_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_two_byte,
  output logic [7:0]  instr_pc,
  output logic        halted
`ifdef IFETCH_PERF_CTR_EN
  ,
  output logic [15:0] instr_count
`endif
);

  fetch_state_e state_q;
  logic [7:0]   pc_q;
  logic [7:0]   pc_inc;
  logic [7:0]   opcode_q;
  logic [7:0]   operand_q;
  logic         two_byte_q;
  logic [7:0]   instr_pc_q;
  logic         valid_q;
  logic         halted_q;
  logic         transfer;

  // 8-bit wrap is intentional: an operand after 8'hFF comes from 8'h00.
  assign pc_inc   = pc_q + 8'd1;
  assign transfer = valid_q & instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OP;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      two_byte_q <= 1'b0;
      instr_pc_q <= 8'h00;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else if (pc_load) begin
      // Drops any partial or unaccepted instruction; a same-cycle accept
      // still counts as transferred.
      state_q  <= S_OP;
      pc_q     <= pc_load_addr;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_OP: begin
          opcode_q   <= imem_data;
          operand_q  <= 8'h00;
          two_byte_q <= is_two_byte(imem_data);
          instr_pc_q <= pc_q;
          pc_q       <= pc_inc;
          if (is_two_byte(imem_data)) begin
            state_q <= S_IMM;
          end else begin
            state_q <= S_VALID;
            valid_q <= 1'b1;
          end
        end
        S_IMM: begin
          operand_q <= imem_data;
          pc_q      <= pc_inc;
          state_q   <= S_VALID;
          valid_q   <= 1'b1;
        end
        S_VALID: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (opcode_q == OPC_HLT) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_OP;
            end
          end
        end
        S_HALT: begin
          // Frozen until pc_load or rst.
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CTR_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (transfer) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign instr_opcode   = opcode_q;
  assign instr_operand  = operand_q;
  assign instr_two_byte = two_byte_q;
  assign instr_pc       = instr_pc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// A second instance with RESET_PC=8'hFF covers PC wrap-around.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr, imem_data;
  logic        pc_load;
  logic [7:0]  pc_load_addr;
  logic        instr_valid, instr_ready;
  logic [7:0]  instr_opcode, instr_operand, instr_pc;
  logic        instr_two_byte, halted;
  logic [7:0]  mem [256];

  logic [7:0]  w_imem_addr, w_imem_data;
  logic        w_instr_valid;
  logic [7:0]  w_instr_opcode, w_instr_operand, w_instr_pc;
  logic        w_instr_two_byte, w_halted;
  logic [7:0]  mem_w [256];

`ifdef IFETCH_PERF_CTR_EN
  logic [15:0] instr_count, w_instr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data   = mem[imem_addr];
  assign w_imem_data = mem_w[w_imem_addr];

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pc_load        (pc_load),
    .pc_load_addr   (pc_load_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .instr_two_byte (instr_two_byte),
    .instr_pc       (instr_pc),
    .halted         (halted)
`ifdef IFETCH_PERF_CTR_EN
    ,
    .instr_count    (instr_count)
`endif
  );

  instruction_fetch #(.RESET_PC(8'hFF)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_imem_addr),
    .imem_data      (w_imem_data),
    .pc_load        (1'b0),
    .pc_load_addr   (8'h00),
    .instr_valid    (w_instr_valid),
    .instr_ready    (1'b1),
    .instr_opcode   (w_instr_opcode),
    .instr_operand  (w_instr_operand),
    .instr_two_byte (w_instr_two_byte),
    .instr_pc       (w_instr_pc),
    .halted         (w_halted)
`ifdef IFETCH_PERF_CTR_EN
    ,
    .instr_count    (w_instr_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_image();
    logic [7:0] img [9];
    img = '{8'h90, 8'h0A, 8'h94, 8'h0B, 8'h18, 8'h1A, 8'hD8, 8'h0D, 8'hFF};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 9; i++) mem[i] = img[i];
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {15'd0, instr_valid}, 16'd1);
  endtask

  // Expects the next instruction, then (with instr_ready=1) transfers it.
  task automatic expect_instr(input string tag, input logic [7:0] op, input logic [7:0] opd,
                              input logic two, input logic [7:0] pc);
    wait_valid(tag);
    check({tag, "_op"}, {8'd0, instr_opcode}, {8'd0, op});
    check({tag, "_opd"}, {8'd0, instr_operand}, {8'd0, opd});
    check({tag, "_two"}, {15'd0, instr_two_byte}, {15'd0, two});
    check({tag, "_pc"}, {8'd0, instr_pc}, {8'd0, pc});
    tick();
  endtask

  task automatic run_image();
    expect_instr("i0", 8'h90, 8'h0A, 1'b1, 8'h00);
    expect_instr("i1", 8'h94, 8'h0B, 1'b1, 8'h02);
    expect_instr("i2", 8'h18, 8'h00, 1'b0, 8'h04);
    expect_instr("i3", 8'h1A, 8'h00, 1'b0, 8'h05);
    expect_instr("i4", 8'hD8, 8'h0D, 1'b1, 8'h06);
    expect_instr("i5", 8'hFF, 8'h00, 1'b0, 8'h08);
  endtask

  initial begin
    rst          = 1'b1;
    pc_load      = 1'b0;
    pc_load_addr = 8'h00;
    instr_ready  = 1'b0;
    load_image();
    for (int i = 0; i < 256; i++) mem_w[i] = 8'h00;
    mem_w[8'hFF] = 8'h94;
    mem_w[8'h00] = 8'h33;
    mem_w[8'h01] = 8'h18;

    // Reset state, sampled while rst is held.
    tick();
    tick();
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_addr", {8'd0, imem_addr}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_opcode", {8'd0, instr_opcode}, 16'h0000);
    check("rst_pc", {8'd0, instr_pc}, 16'h0000);
    check("rst_w_addr", {8'd0, w_imem_addr}, 16'h00FF);
    rst = 1'b0;

    // Wrap: 2-byte opcode at FF takes its operand from 00.
    begin
      int n = 0;
      while (!w_instr_valid && n < 8) begin
        tick();
        n++;
      end
      check("wrap_valid", {15'd0, w_instr_valid}, 16'd1);
      check("wrap_op", {8'd0, w_instr_opcode}, 16'h0094);
      check("wrap_opd", {8'd0, w_instr_operand}, 16'h0033);
      check("wrap_pc", {8'd0, w_instr_pc}, 16'h00FF);
      tick();
      check("wrap_next_addr", {8'd0, w_imem_addr}, 16'h0001);
    end

    // Full image with decode always ready.
    do_reset();
    instr_ready = 1'b1;
    run_image();
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_valid", {15'd0, instr_valid}, 16'd0);
    check("halt_addr", {8'd0, imem_addr}, 16'h0009);
    repeat (3) tick();
    check("halt_addr_hold", {8'd0, imem_addr}, 16'h0009);
    check("halt_flag_hold", {15'd0, halted}, 16'd1);
`ifdef IFETCH_PERF_CTR_EN
    check("count_6", instr_count, 16'd6);
`endif

    // Redirect out of halt.
    pc_load      = 1'b1;
    pc_load_addr = 8'h04;
    tick();
    pc_load = 1'b0;
    check("unhalt_flag", {15'd0, halted}, 16'd0);
    check("unhalt_addr", {8'd0, imem_addr}, 16'h0004);
    expect_instr("unhalt", 8'h18, 8'h00, 1'b0, 8'h04);

    // Reset while an instruction is presented.
    do_reset();
    instr_ready = 1'b0;
    wait_valid("rsv");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsv_valid", {15'd0, instr_valid}, 16'd0);
    check("rsv_addr", {8'd0, imem_addr}, 16'h0000);
`ifdef IFETCH_PERF_CTR_EN
    check("count_rst", instr_count, 16'd0);
`endif

    // Back-pressure: outputs and PC hold until accepted.
    do_reset();
    instr_ready = 1'b0;
    wait_valid("bp");
    repeat (5) tick();
    check("bp_valid", {15'd0, instr_valid}, 16'd1);
    check("bp_op", {8'd0, instr_opcode}, 16'h0090);
    check("bp_opd", {8'd0, instr_operand}, 16'h000A);
    check("bp_pc", {8'd0, instr_pc}, 16'h0000);
    check("bp_addr", {8'd0, imem_addr}, 16'h0002);
    instr_ready = 1'b1;
    tick();
    expect_instr("bp_next", 8'h94, 8'h0B, 1'b1, 8'h02);

    // Redirect while the operand byte is being fetched.
    do_reset();
    instr_ready = 1'b1;
    tick();
    check("imm_addr", {8'd0, imem_addr}, 16'h0001);
    pc_load      = 1'b1;
    pc_load_addr = 8'h04;
    tick();
    pc_load = 1'b0;
    check("imm_valid", {15'd0, instr_valid}, 16'd0);
    check("imm_redir_addr", {8'd0, imem_addr}, 16'h0004);
    expect_instr("imm_next", 8'h18, 8'h00, 1'b0, 8'h04);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
